// File: rtl/wb_write_queue.sv
// Write-back queue buffering register-file writes ahead of the single write port.
// Define WBQ_FORWARD_EN to enable combinational forwarding lookups of pending entries.
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       drain_en,
    output logic [ADDR_W-1:0]          Reg_address3,
    output logic [DATA_W-1:0]          Reg_input_data,
    output logic                       Reg_Write,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic [ADDR_W-1:0]          fwd_addr1,
    input  logic [ADDR_W-1:0]          fwd_addr2,
    output logic                       fwd_hit1,
    output logic [DATA_W-1:0]          fwd_data1,
    output logic                       fwd_hit2,
    output logic [DATA_W-1:0]          fwd_data2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_push  = wb_valid && !w_full;
    assign w_pop   = drain_en && !w_empty;

    assign wb_ready       = !w_full;
    assign Reg_Write      = w_pop;
    assign Reg_address3   = w_empty ? '0 : r_addr[r_head];
    assign Reg_input_data = w_empty ? '0 : r_data[r_head];
    assign count          = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_addr[r_tail] <= wb_addr;
            r_data[r_tail] <= wb_data;
        end
    end

`ifdef WBQ_FORWARD_EN
    logic [PTR_W-1:0] w_idx;

    // Scan oldest to youngest so the youngest match overrides earlier ones.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        w_idx     = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (CNT_W'(i) < r_count) begin
                if (r_addr[w_idx] == fwd_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = r_data[w_idx];
                end
                if (r_addr[w_idx] == fwd_addr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = r_data[w_idx];
                end
            end
        end
    end
`else
    logic w_unused_fwd;

    assign w_unused_fwd = ^{fwd_addr1, fwd_addr2};
    assign fwd_hit1     = 1'b0;
    assign fwd_data1    = '0;
    assign fwd_hit2     = 1'b0;
    assign fwd_data2    = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: latency, fill/stall, wrap, ordering, forwarding, reset.
// Forwarding expectations follow WBQ_FORWARD_EN when the bench is built with it.
module tb_wb_write_queue;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        drain_en;
    logic [2:0]  Reg_address3;
    logic [15:0] Reg_input_data;
    logic        Reg_Write;
    logic [2:0]  count;
    logic [2:0]  fwd_addr1;
    logic [2:0]  fwd_addr2;
    logic        fwd_hit1;
    logic [15:0] fwd_data1;
    logic        fwd_hit2;
    logic [15:0] fwd_data2;

    int n_checks = 0;
    int n_errors = 0;

    logic [18:0] log_q [$];
    logic [15:0] rf [8];
    logic [18:0] exp_q [$];

`ifdef WBQ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    wb_write_queue dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .drain_en       (drain_en),
        .Reg_address3   (Reg_address3),
        .Reg_input_data (Reg_input_data),
        .Reg_Write      (Reg_Write),
        .count          (count),
        .fwd_addr1      (fwd_addr1),
        .fwd_addr2      (fwd_addr2),
        .fwd_hit1       (fwd_hit1),
        .fwd_data1      (fwd_data1),
        .fwd_hit2       (fwd_hit2),
        .fwd_data2      (fwd_data2)
    );

    always #5 CLK = ~CLK;

    // Stand-in register file: captures whatever the commit port presents.
    always @(posedge CLK) begin
        if (Reg_Write) begin
            log_q.push_back({Reg_address3, Reg_input_data});
            rf[Reg_address3] = Reg_input_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [2:0] a, input logic [15:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        Reset     = 1'b0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        drain_en  = 1'b0;
        fwd_addr1 = '0;
        fwd_addr2 = '0;
        for (int i = 0; i < 8; i++) rf[i] = '0;
        tick();
        tick();
        Reset = 1'b1;
        #1;
        check("rst_write",  32'(Reg_Write), 0);
        check("rst_addr",   32'(Reg_address3), 0);
        check("rst_data",   32'(Reg_input_data), 0);
        check("rst_count",  32'(count), 0);
        check("rst_ready",  32'(wb_ready), 1);
        check("rst_hit1",   32'(fwd_hit1), 0);
        check("rst_fdata1", 32'(fwd_data1), 0);

        // Single write: accepted at edge N, committed at N+1.
        drain_en = 1'b1;
        push(3'd5, 16'hBEEF);
        #1;
        check("one_write", 32'(Reg_Write), 1);
        check("one_addr",  32'(Reg_address3), 5);
        check("one_data",  32'(Reg_input_data), 32'h0000BEEF);
        check("one_count", 32'(count), 1);
        tick();
        check("one_count_after", 32'(count), 0);
        check("one_write_after", 32'(Reg_Write), 0);
        check("one_rf5", 32'(rf[5]), 32'h0000BEEF);

        // Fill and stall.
        drain_en = 1'b0;
        log_q.delete();
        for (int i = 1; i <= 4; i++) push(3'(i), 16'(i));
        #1;
        check("full_count", 32'(count), 4);
        check("full_ready", 32'(wb_ready), 0);
        check("full_head",  32'(Reg_address3), 1);
        check("full_nowr",  32'(Reg_Write), 0);
        wb_valid = 1'b1;
        wb_addr  = 3'd7;
        wb_data  = 16'h0077;
        tick();
        check("stall_count", 32'(count), 4);
        drain_en = 1'b1;
        #1;
        check("full_pop_ready", 32'(wb_ready), 0);
        check("full_pop_write", 32'(Reg_Write), 1);
        tick();
        check("after_pop_count", 32'(count), 3);
        check("after_pop_ready", 32'(wb_ready), 1);
        tick();
        wb_valid = 1'b0;
        check("pushpop_count", 32'(count), 3);
        tick();
        tick();
        tick();
        check("drained_count", 32'(count), 0);
        exp_q = '{{3'd1, 16'd1}, {3'd2, 16'd2}, {3'd3, 16'd3}, {3'd4, 16'd4}, {3'd7, 16'h0077}};
        check_log("fill_order");

        // Simultaneous push/pop at count 2 across pointer wraps.
        drain_en = 1'b0;
        log_q.delete();
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            push(3'(k), 16'h1000 + 16'(k));
            exp_q.push_back({3'(k), 16'h1000 + 16'(k)});
        end
        drain_en = 1'b1;
        for (int k = 2; k < 12; k++) begin
            push(3'(k), 16'h1000 + 16'(k));
            exp_q.push_back({3'(k), 16'h1000 + 16'(k)});
            check($sformatf("wrap_count_%0d", k), 32'(count), 2);
        end
        tick();
        tick();
        check("wrap_empty", 32'(count), 0);
        check_log("wrap_order");

        // Same-register ordering and forwarding.
        drain_en  = 1'b0;
        push(3'd3, 16'h0001);
        push(3'd3, 16'h0002);
        fwd_addr1 = 3'd3;
        fwd_addr2 = 3'd6;
        #1;
        check("fwd_hit1",  32'(fwd_hit1), FWD ? 1 : 0);
        check("fwd_data1", 32'(fwd_data1), FWD ? 2 : 0);
        check("fwd_hit2",  32'(fwd_hit2), 0);
        check("fwd_data2", 32'(fwd_data2), 0);
        fwd_addr2 = 3'd3;
        drain_en  = 1'b1;
        #1;
        check("fwd_head_hit2",  32'(fwd_hit2), FWD ? 1 : 0);
        check("fwd_head_data2", 32'(fwd_data2), FWD ? 2 : 0);
        tick();
        check("fwd_last_data1", 32'(fwd_data1), FWD ? 2 : 0);
        tick();
        check("same_reg_rf3", 32'(rf[3]), 2);
        check("fwd_hit1_gone", 32'(fwd_hit1), 0);
        check("same_reg_count", 32'(count), 0);

        // Reset mid-operation discards pending entries.
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) push(3'(i + 4), 16'hA000 + 16'(i));
        check("pre_rst_count", 32'(count), 3);
        log_q.delete();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
        check("mid_rst_write", 32'(Reg_Write), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_ready", 32'(wb_ready), 1);
        check("mid_rst_addr",  32'(Reg_address3), 0);
        drain_en = 1'b1;
        #1;
        check("mid_rst_nowr", 32'(Reg_Write), 0);
        tick();
        tick();
        tick();
        check("mid_rst_nocommit", 32'(log_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-back queue that sits in front of the 8x16-bit register file's single write port (Reg_address3 / Reg_input_data / Reg_Write).
- Accepts register-write requests from the execute and memory stages over a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO into the register file at one write per cycle while drain_en is high.
- Optionally exposes forwarding lookups so read ports see pending, not-yet-committed values.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width (8 registers).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset.
- wb_valid  input  1  producer has a write request.
- wb_ready  output  1  queue can accept; equals !full.
- wb_addr  input  ADDR_W  destination register.
- wb_data  input  DATA_W  write data.
- drain_en  input  1  register file write port available this cycle.
- Reg_address3  output  ADDR_W  head-entry address to register file.
- Reg_input_data  output  DATA_W  head-entry data to register file.
- Reg_Write  output  1  commit head entry this cycle.
- count  output  $clog2(DEPTH+1)  occupied entries.
- fwd_addr1  input  ADDR_W  forwarding lookup address 1.
- fwd_addr2  input  ADDR_W  forwarding lookup address 2.
- fwd_hit1  output  1  a pending entry matches fwd_addr1.
- fwd_data1  output  DATA_W  youngest matching pending data for fwd_addr1.
- fwd_hit2  output  1  a pending entry matches fwd_addr2.
- fwd_data2  output  DATA_W  youngest matching pending data for fwd_addr2.

Behaviour:
- Storage: circular buffer, head/tail pointers plus count register.
  - empty = (count==0); full = (count==DEPTH).
- Push: wb_valid && wb_ready at a rising edge.
  - Entry written at tail; tail increments modulo DEPTH.
- Pop: Reg_Write at a rising edge; head increments modulo DEPTH.
- Commit port (combinational from head):
  - Reg_Write = drain_en && !empty.
  - Reg_address3 / Reg_input_data = head entry when !empty; all zeros when empty.
  - The register file captures on the same edge that pops the entry.
- Latency: request accepted at edge N into an empty queue with drain_en high commits at edge N+1. No same-cycle bypass from wb_* to Reg_*.
- Simultaneous push and pop: count unchanged, both pointers advance.
- wb_ready = !full, strictly. A full queue does not accept even if popping that cycle.
- Ordering: strict FIFO. Two writes to the same register commit in arrival order, so the last one wins in the register file.
- Register 0 is not special: writes to address 0 are queued and committed like any other.
- wb_valid while !wb_ready: the request is ignored. The producer must hold wb_valid, wb_addr and wb_data until accepted.
- Reset (Reset==0 at a rising edge):
  - Head, tail and count go to 0; entry contents are don't-care.
  - Outputs after reset: Reg_Write=0, Reg_address3=0, Reg_input_data=0, count=0, wb_ready=1, fwd_hit*=0, fwd_data*=0.
  - Reset mid-operation discards all pending entries; nothing commits on the reset edge.
- Pointer wrap-around: correct across any number of wraps; count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: WBQ_FORWARD_EN.
- Defined:
  - fwd_hitN = 1 when any occupied entry's address equals fwd_addrN.
  - fwd_dataN = data of the youngest matching entry (closest to tail).
  - Search is combinational and includes the head entry even while it is being committed.
- Not defined:
  - No comparison logic is generated; fwd_hit1, fwd_hit2, fwd_data1 and fwd_data2 are tied to 0.
  - fwd_addr1 and fwd_addr2 are unused.
  - Port list is unchanged.

Test Plan:
- Reset then single write: drain_en=1, push addr=5 data=16'hBEEF at edge N -> cycle after N shows Reg_Write=1, Reg_address3=5, Reg_input_data=16'hBEEF; count returns to 0 after edge N+1.
- Fill and stall: drain_en=0, push 4 entries (r1=1, r2=2, r3=3, r4=4) -> count=4, wb_ready=0; a 5th wb_valid is held off. Raise drain_en -> commits r1..r4 in order, one per cycle, then the 5th is accepted.
- Simultaneous push/pop at count=2 -> count stays 2; run 10 such cycles -> pointers wrap and the commit order matches push order.
- Same-register ordering: push r3=16'h0001 then r3=16'h0002 with drain_en=0 -> with WBQ_FORWARD_EN, fwd_addr1=3 gives fwd_hit1=1, fwd_data1=16'h0002, and fwd_addr2=6 gives fwd_hit2=0. After draining, r3 holds 16'h0002 and fwd_hit1=0. Without the macro, both hits stay 0.
- Reset mid-operation: 3 entries pending, Reset=0 for one edge -> Reg_Write=0, count=0, wb_ready=1 immediately after; no pending entry is ever committed.
